// File: rtl/vga_mode_sequencer_if.sv
// vga_mode_sequencer_if
//   Groups the front-panel keys, the frame-boundary strobe and the mode
//   outputs of the VGA mode sequencer into one bundle.
//   master : the side that drives keys/frame_start and observes the mode
//            (timing generator / front panel / testbench).
//   slave  : the mode sequencer itself.
//   Signals:
//     key1_n      advance key, active-low, raw (asynchronous, bouncy)
//     key2_n      auto-mode toggle key, active-low, raw
//     frame_start 1-cycle pulse at the first clock of vsync
//     dis_mode    current 4-bit pattern select
//     mode_chg    1-cycle pulse when dis_mode takes a new value
//     auto_on     auto-cycle active
//     led         mirror of auto_on
interface vga_mode_sequencer_if;
    logic       key1_n;
    logic       key2_n;
    logic       frame_start;
    logic [3:0] dis_mode;
    logic       mode_chg;
    logic       auto_on;
    logic       led;

    modport master (
        output key1_n, key2_n, frame_start,
        input  dis_mode, mode_chg, auto_on, led
    );

    modport slave (
        input  key1_n, key2_n, frame_start,
        output dis_mode, mode_chg, auto_on, led
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer
//   Display-mode controller for the VGA test-pattern generator. Debounces the
//   front-panel keys and steps the 4-bit pattern select, applying every change
//   only on a frame_start cycle so no frame ever shows a torn pattern.
//   Optional auto-cycle mode advances the pattern every DWELL_FRAMES frames.
//   Configuration macro: VGA_MODE_SEQ_AUTO_EN
//     defined   -> AUTO state, frame counter and key2 path are built
//     undefined -> fixed manual operation; auto_on/led tied low, key2_n ignored
//   Ports:
//     clk  pixel clock, all logic on posedge
//     rst  synchronous reset, active-high
//     bus  vga_mode_sequencer_if.slave (keys, frame_start, dis_mode,
//          mode_chg, auto_on, led)
module vga_mode_sequencer #(
    parameter int DEBOUNCE_CYC = 90000,
    parameter int NUM_MODES    = 14,
    parameter int DWELL_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_mode_sequencer_if.slave  bus
);

    localparam int             DW        = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0]  DEB_MAX   = DW'(DEBOUNCE_CYC);
    localparam logic [DW-1:0]  DEB_PRE   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]     LAST_MODE = 4'(NUM_MODES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Debounce counter step: cleared by any released sample, otherwise counts
    // up and parks at DEBOUNCE_CYC so a long hold yields only one event.
    function automatic logic [DW-1:0] deb_next(input logic sync_n, input logic [DW-1:0] cnt);
        logic [DW-1:0] nxt;
        if (sync_n) begin
            nxt = {DW{1'b0}};
        end else if (cnt != DEB_MAX) begin
            nxt = cnt + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic           key1_meta_r;
    logic           key1_sync_r;
    logic [DW-1:0]  key1_cnt_r;
    logic           key1_evt_s;
    logic           key2_evt_s;
    logic           dwell_exp_s;
    logic           adv_req_s;
    logic           apply_s;
    logic           pend_r;
    logic [3:0]     dis_mode_r;
    logic           mode_chg_r;

    // key1 two-flop synchroniser (preset released) and debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            key1_meta_r <= 1'b1;
            key1_sync_r <= 1'b1;
            key1_cnt_r  <= {DW{1'b0}};
        end else begin
            key1_meta_r <= bus.key1_n;
            key1_sync_r <= key1_meta_r;
            key1_cnt_r  <= deb_next(key1_sync_r, key1_cnt_r);
        end
    end

    // Event fires on the DEBOUNCE_CYC-1 -> DEBOUNCE_CYC transition only.
    assign key1_evt_s = ~key1_sync_r && (key1_cnt_r == DEB_PRE);

`ifdef VGA_MODE_SEQ_AUTO_EN
    localparam int            FW         = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [FW-1:0] DWELL_LAST = FW'(DWELL_FRAMES - 1);

    logic           key2_meta_r;
    logic           key2_sync_r;
    logic [DW-1:0]  key2_cnt_r;
    logic [FW-1:0]  frame_cnt_r;
    logic           auto_on_r;

    // key2 two-flop synchroniser (preset released) and debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            key2_meta_r <= 1'b1;
            key2_sync_r <= 1'b1;
            key2_cnt_r  <= {DW{1'b0}};
        end else begin
            key2_meta_r <= bus.key2_n;
            key2_sync_r <= key2_meta_r;
            key2_cnt_r  <= deb_next(key2_sync_r, key2_cnt_r);
        end
    end

    assign key2_evt_s  = ~key2_sync_r && (key2_cnt_r == DEB_PRE);

    // Expiry is only honoured in AUTO; the FSM decode gates it by state.
    assign dwell_exp_s = bus.frame_start && (frame_cnt_r == DWELL_LAST);

    // Frames shown in the current mode; restarts on any applied step and on AUTO entry
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {FW{1'b0}};
        end else if (apply_s || ((state_r == MANUAL) && (state_nxt_s == AUTO))) begin
            frame_cnt_r <= {FW{1'b0}};
        end else if ((state_r == AUTO) && bus.frame_start) begin
            frame_cnt_r <= frame_cnt_r + {{(FW-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // auto_on register tracks the state register exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_on_r <= 1'b0;
        end else begin
            auto_on_r <= (state_nxt_s == AUTO);
        end
    end

    assign bus.auto_on = auto_on_r;
    assign bus.led     = auto_on_r;
`else
    logic unused_key2_s;

    assign unused_key2_s = bus.key2_n;
    assign key2_evt_s    = 1'b0;
    assign dwell_exp_s   = 1'b0;
    assign bus.auto_on   = 1'b0;
    assign bus.led       = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MANUAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state (key2 toggles, not frame-gated) and advance-source decode
    always_comb begin
        state_nxt_s = state_r;
        adv_req_s   = 1'b0;
        case (state_r)
            MANUAL: begin
                adv_req_s = pend_r | key1_evt_s;
`ifdef VGA_MODE_SEQ_AUTO_EN
                if (key2_evt_s) begin
                    state_nxt_s = AUTO;
                end else begin
                    state_nxt_s = MANUAL;
                end
`else
                state_nxt_s = MANUAL;
`endif
            end
            AUTO: begin
                adv_req_s = pend_r | key1_evt_s | dwell_exp_s;
                if (key2_evt_s) begin
                    state_nxt_s = MANUAL;
                end else begin
                    state_nxt_s = AUTO;
                end
            end
            default: begin
                state_nxt_s = MANUAL;
                adv_req_s   = 1'b0;
            end
        endcase
    end

    // All sources collapse into one +1 step, and only on a frame boundary.
    assign apply_s = bus.frame_start && adv_req_s;

    // Mode register, change pulse and pending-advance flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dis_mode_r <= 4'd0;
            mode_chg_r <= 1'b0;
            pend_r     <= 1'b0;
        end else begin
            mode_chg_r <= apply_s;
            if (apply_s) begin
                dis_mode_r <= (dis_mode_r == LAST_MODE) ? 4'd0 : dis_mode_r + 4'd1;
                pend_r     <= 1'b0;
            end else if (key1_evt_s) begin
                pend_r     <= 1'b1;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

    assign bus.dis_mode = dis_mode_r;
    assign bus.mode_chg = mode_chg_r;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb_vga_mode_sequencer
//   Directed bench for vga_mode_sequencer with DEBOUNCE_CYC=8, NUM_MODES=14,
//   DWELL_FRAMES=3 and a frame_start pulse every 100 clocks. A behavioural
//   model (key low-run lengths, pending flag, frames-in-mode count) predicts
//   the outputs every cycle; literal checks pin the model at key points.
module tb_vga_mode_sequencer;

    localparam int DEB    = 8;
    localparam int NMODES = 14;
    localparam int DWELL  = 3;
    localparam int FRAME  = 100;

    logic clk;
    logic rst;
    int   ph;
    int   checks;
    int   errors;
    int   printed;

    vga_mode_sequencer_if bus ();

    vga_mode_sequencer #(
        .DEBOUNCE_CYC (DEB),
        .NUM_MODES    (NMODES),
        .DWELL_FRAMES (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: r*a/r*b = raw low-run length one and two edges ago.
    typedef struct {
        int r1a;
        int r1b;
        int r2a;
        int r2b;
        int pend;
        int mode;
        int chg;
        int auto_on;
        int frames;
    } mstate_t;

    mstate_t m;
    bit      m_valid;

    function automatic mstate_t model_step(input mstate_t s, input logic k1, input logic k2, input logic fs);
        mstate_t n;
        bit evt1;
        bit evt2;
        bit dwell;
        bit apply;
        n     = s;
        // A press is recognised once the synchronised key has been low for
        // DEB consecutive samples; synchronisation delays the raw key by 2.
        evt1  = (s.r1b == DEB);
        n.r1b = s.r1a;
        n.r1a = k1 ? 0 : s.r1a + 1;
`ifdef VGA_MODE_SEQ_AUTO_EN
        evt2  = (s.r2b == DEB);
        n.r2b = s.r2a;
        n.r2a = k2 ? 0 : s.r2a + 1;
`else
        evt2  = 1'b0;
`endif
        dwell = (s.auto_on != 0) && fs && (s.frames == DWELL - 1);
        apply = fs && ((s.pend != 0) || evt1 || dwell);
        n.chg = apply ? 1 : 0;
        if (apply) begin
            n.mode = (s.mode + 1) % NMODES;
            n.pend = 0;
        end else if (evt1) begin
            n.pend = 1;
        end
        if ((evt2 && s.auto_on == 0) || apply) begin
            n.frames = 0;
        end else if (s.auto_on != 0 && fs) begin
            n.frames = s.frames + 1;
        end
        if (evt2) begin
            n.auto_on = (s.auto_on != 0) ? 0 : 1;
        end
        return n;
    endfunction

    // Model advance at each active edge
    always @(posedge clk) begin
        if (rst) begin
            m       <= '{default: 0};
            m_valid <= 1'b1;
        end else begin
            m <= model_step(m, bus.key1_n, bus.key2_n, bus.frame_start);
        end
    end

    task automatic report(input string name, input int act, input int exp);
        if (printed < 40) begin
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
            printed++;
        end
    endtask

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus.dis_mode !== 4'(m.mode)) begin
                errors++;
                report("model_dis_mode", int'(bus.dis_mode), m.mode);
            end
            checks++;
            if (bus.mode_chg !== 1'(m.chg)) begin
                errors++;
                report("model_mode_chg", int'(bus.mode_chg), m.chg);
            end
            checks++;
            if (bus.auto_on !== 1'(m.auto_on)) begin
                errors++;
                report("model_auto_on", int'(bus.auto_on), m.auto_on);
            end
            checks++;
            if (bus.led !== 1'(m.auto_on)) begin
                errors++;
                report("model_led", int'(bus.led), m.auto_on);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: frame_start is high for the edge whose phase is FRAME-1.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_start = (ph == FRAME - 1);
            ph = (ph + 1) % FRAME;
        end
    endtask

    task automatic step_to(input int p);
        while (ph != p) step(1);
    endtask

    task automatic frame_edge();
        step_to(0);
        step(1);
    endtask

    task automatic press1(input int n);
        bus.key1_n = 1'b0;
        step(n);
        bus.key1_n = 1'b1;
        step(4);
    endtask

    task automatic press2(input int n);
        bus.key2_n = 1'b0;
        step(n);
        bus.key2_n = 1'b1;
        step(4);
    endtask

    task automatic adv_one();
        step_to(10);
        press1(12);
        frame_edge();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        printed        = 0;
        ph             = 0;
        m_valid        = 1'b0;
        rst            = 1'b1;
        bus.key1_n     = 1'b1;
        bus.key2_n     = 1'b1;
        bus.frame_start = 1'b0;
        step(3);
        rst = 1'b0;
        chk("reset_dis_mode", int'(bus.dis_mode), 0);
        chk("reset_mode_chg", int'(bus.mode_chg), 0);
        chk("reset_auto_on", int'(bus.auto_on), 0);
        chk("reset_led", int'(bus.led), 0);

        // 1: long press mid-frame, applied at the next frame_start
        step_to(30);
        press1(20);
        step_to(0);
        chk("t1_before_frame", int'(bus.dis_mode), 0);
        step(1);
        chk("t1_dis_mode", int'(bus.dis_mode), 1);
        chk("t1_mode_chg", int'(bus.mode_chg), 1);
        step(1);
        chk("t1_chg_pulse_end", int'(bus.mode_chg), 0);

        // 2: bouncing key never reaches the debounce count
        step_to(10);
        repeat (5) begin
            bus.key1_n = 1'b0;
            step(3);
            bus.key1_n = 1'b1;
            step(1);
        end
        repeat (3) frame_edge();
        chk("t2_bounce_no_adv", int'(bus.dis_mode), 1);

        // 3: three presses in one frame merge into a single step
        step_to(5);
        repeat (3) press1(12);
        frame_edge();
        chk("t3_merged_adv", int'(bus.dis_mode), 2);
        chk("t3_merged_chg", int'(bus.mode_chg), 1);
        frame_edge();
        chk("t3_no_second_adv", int'(bus.dis_mode), 2);
        chk("t3_no_second_chg", int'(bus.mode_chg), 0);
        repeat (11) adv_one();
        chk("t3_reach_last", int'(bus.dis_mode), 13);
        adv_one();
        chk("t3_wrap", int'(bus.dis_mode), 0);
        chk("t3_wrap_chg", int'(bus.mode_chg), 1);

`ifdef VGA_MODE_SEQ_AUTO_EN
        // 4: auto mode steps every third frame, stops on second key2 press
        step_to(10);
        press2(12);
        chk("t4_auto_on", int'(bus.auto_on), 1);
        chk("t4_led", int'(bus.led), 1);
        repeat (2) frame_edge();
        chk("t4_two_frames", int'(bus.dis_mode), 0);
        frame_edge();
        chk("t4_three_frames", int'(bus.dis_mode), 1);
        repeat (3) frame_edge();
        chk("t4_six_frames", int'(bus.dis_mode), 2);
        repeat (3) frame_edge();
        chk("t4_nine_frames", int'(bus.dis_mode), 3);
        step_to(10);
        press2(12);
        chk("t4_auto_off", int'(bus.auto_on), 0);
        repeat (3) frame_edge();
        chk("t4_stopped", int'(bus.dis_mode), 3);

        // 5: key1 event coincident with dwell expiry gives exactly one step
        step_to(10);
        press2(12);
        chk("t5_auto_on", int'(bus.auto_on), 1);
        repeat (2) frame_edge();
        chk("t5_pre_expiry", int'(bus.dis_mode), 3);
        step_to(91);
        bus.key1_n = 1'b0;
        frame_edge();
        chk("t5_single_step", int'(bus.dis_mode), 4);
        chk("t5_chg", int'(bus.mode_chg), 1);
        bus.key1_n = 1'b1;
        step(1);
        chk("t5_chg_end", int'(bus.mode_chg), 0);
        repeat (2) frame_edge();
        chk("t5_dwell_restart", int'(bus.dis_mode), 4);
        frame_edge();
        chk("t5_dwell_expire", int'(bus.dis_mode), 5);
`else
        // Manual build: key2 is ignored, reach mode 5 by presses
        step_to(10);
        press2(12);
        chk("nauto_key2_ignored", int'(bus.auto_on), 0);
        repeat (5) adv_one();
        chk("nauto_mode5", int'(bus.dis_mode), 5);
`endif

        // 6: reset with a pending request discards it
        step_to(10);
        press1(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_dis_mode", int'(bus.dis_mode), 0);
        chk("t6_mode_chg", int'(bus.mode_chg), 0);
        chk("t6_auto_on", int'(bus.auto_on), 0);
        chk("t6_led", int'(bus.led), 0);
        frame_edge();
        chk("t6_no_chg", int'(bus.mode_chg), 0);
        chk("t6_no_adv", int'(bus.dis_mode), 0);
        repeat (3) frame_edge();
        chk("t6_still_zero", int'(bus.dis_mode), 0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
